// File: rtl/oled_init_seq_pkg.sv
// Shared types and constants for the SSD1306 power-up sequencer: table op codes,
// pin/delay selectors, panel command bytes and FSM state encoding.
package oled_pkg;

  typedef enum logic [1:0] {
    OP_PIN = 2'd0,
    OP_CMD = 2'd1,
    OP_DLY = 2'd2,
    OP_END = 2'd3
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [7:0] arg;
  } rom_entry_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_WAITD = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int STEP_W = 5;

  // PIN arg: [1:0] selects the pin, [7] is the level to drive
  localparam logic [1:0] PIN_VDDC  = 2'd0;
  localparam logic [1:0] PIN_VBATC = 2'd1;
  localparam logic [1:0] PIN_RES   = 2'd2;

  localparam logic [7:0] DLY_VDD  = 8'd0;
  localparam logic [7:0] DLY_RES  = 8'd1;
  localparam logic [7:0] DLY_VBAT = 8'd2;

  localparam logic [7:0] DISP_OFF      = 8'hAE;
  localparam logic [7:0] CHG_PUMP      = 8'h8D;
  localparam logic [7:0] CHG_PUMP_ON   = 8'h14;
  localparam logic [7:0] PRECHARGE     = 8'hD9;
  localparam logic [7:0] PRECHARGE_VAL = 8'hF1;
  localparam logic [7:0] SET_CONTRAST  = 8'h81;
  localparam logic [7:0] SEG_REMAP     = 8'hA0;
  localparam logic [7:0] COM_SCAN      = 8'hC0;
  localparam logic [7:0] COM_PINS      = 8'hDA;
  localparam logic [7:0] COM_PINS_VAL  = 8'h00;
  localparam logic [7:0] DISP_ON       = 8'hAF;

  function automatic logic [7:0] pin_arg(input logic [1:0] sel, input logic level);
    return {level, 5'b0, sel};
  endfunction

endpackage

// File: rtl/oled_init_seq_if.sv
// Bundle between the init sequencer, the ms Delay block, the SPI byte controller and the panel pins.
interface oled_init_seq_if;
  logic        EN;
  logic        FIN;
  logic [11:0] DELAY_MS;
  logic        DELAY_EN;
  logic        DELAY_FIN;
  logic [7:0]  SPI_DATA;
  logic        SPI_EN;
  logic        SPI_FIN;
  logic        DC;
  logic        RES;
  logic        VBATC;
  logic        VDDC;

  modport master (
    input  EN, DELAY_FIN, SPI_FIN,
    output FIN, DELAY_MS, DELAY_EN, SPI_DATA, SPI_EN, DC, RES, VBATC, VDDC
  );

  modport slave (
    output EN, DELAY_FIN, SPI_FIN,
    input  FIN, DELAY_MS, DELAY_EN, SPI_DATA, SPI_EN, DC, RES, VBATC, VDDC
  );
endinterface

// File: rtl/oled_init_seq_rom.sv
// Fixed SSD1306 power-up table: step index -> {op, arg}. Steps past END read as END.
module oled_init_rom
  import oled_pkg::*;
#(
  parameter logic [7:0] CONTRAST = 8'h0F
) (
  input  logic [STEP_W-1:0] step,
  output rom_entry_t        entry
);

  always_comb begin
    entry = '{op: OP_END, arg: 8'h00};
    case (step)
      5'd0:  entry = '{op: OP_PIN, arg: pin_arg(PIN_VDDC, 1'b0)};
      5'd1:  entry = '{op: OP_DLY, arg: DLY_VDD};
      5'd2:  entry = '{op: OP_CMD, arg: DISP_OFF};
      5'd3:  entry = '{op: OP_PIN, arg: pin_arg(PIN_RES, 1'b0)};
      5'd4:  entry = '{op: OP_DLY, arg: DLY_RES};
      5'd5:  entry = '{op: OP_PIN, arg: pin_arg(PIN_RES, 1'b1)};
      5'd6:  entry = '{op: OP_DLY, arg: DLY_RES};
      5'd7:  entry = '{op: OP_CMD, arg: CHG_PUMP};
      5'd8:  entry = '{op: OP_CMD, arg: CHG_PUMP_ON};
      5'd9:  entry = '{op: OP_CMD, arg: PRECHARGE};
      5'd10: entry = '{op: OP_CMD, arg: PRECHARGE_VAL};
      5'd11: entry = '{op: OP_PIN, arg: pin_arg(PIN_VBATC, 1'b0)};
      5'd12: entry = '{op: OP_DLY, arg: DLY_VBAT};
      5'd13: entry = '{op: OP_CMD, arg: SET_CONTRAST};
      5'd14: entry = '{op: OP_CMD, arg: CONTRAST};
      5'd15: entry = '{op: OP_CMD, arg: SEG_REMAP};
      5'd16: entry = '{op: OP_CMD, arg: COM_SCAN};
      5'd17: entry = '{op: OP_CMD, arg: COM_PINS};
      5'd18: entry = '{op: OP_CMD, arg: COM_PINS_VAL};
      5'd19: entry = '{op: OP_CMD, arg: DISP_ON};
      default: entry = '{op: OP_END, arg: 8'h00};
    endcase
  end

endmodule

// File: rtl/oled_init_seq.sv
// SSD1306 power-up sequencer: walks the init table, driving panel pins directly and
// issuing held-until-FIN requests to the ms Delay block and the SPI byte controller.
module oled_init_seq
  import oled_pkg::*;
#(
  parameter logic [11:0] VDD_DELAY_MS  = 12'd1,
  parameter logic [11:0] RES_DELAY_MS  = 12'd1,
  parameter logic [11:0] VBAT_DELAY_MS = 12'd100,
  parameter logic [7:0]  CONTRAST      = 8'h0F
) (
  input  logic             CLK,
  input  logic             RST,
  oled_init_seq_if.master  bus
);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              fin_q, fin_d;
  logic [11:0]       dly_ms_q, dly_ms_d;
  logic              dly_en_q, dly_en_d;
  logic [7:0]        spi_data_q, spi_data_d;
  logic              spi_en_q, spi_en_d;
  logic              res_q, res_d;
  logic              vbatc_q, vbatc_d;
  logic              vddc_q, vddc_d;
  rom_entry_t        entry;

  oled_init_rom #(.CONTRAST(CONTRAST)) u_rom (
    .step  (step_q),
    .entry (entry)
  );

  function automatic logic [11:0] dly_sel(input logic [7:0] sel);
    case (sel)
      DLY_RES:  return RES_DELAY_MS;
      DLY_VBAT: return VBAT_DELAY_MS;
      default:  return VDD_DELAY_MS;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      fin_q      <= 1'b0;
      dly_ms_q   <= '0;
      dly_en_q   <= 1'b0;
      spi_data_q <= '0;
      spi_en_q   <= 1'b0;
      res_q      <= 1'b1;
      vbatc_q    <= 1'b1;
      vddc_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      fin_q      <= fin_d;
      dly_ms_q   <= dly_ms_d;
      dly_en_q   <= dly_en_d;
      spi_data_q <= spi_data_d;
      spi_en_q   <= spi_en_d;
      res_q      <= res_d;
      vbatc_q    <= vbatc_d;
      vddc_q     <= vddc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    fin_d      = fin_q;
    dly_ms_d   = dly_ms_q;
    dly_en_d   = dly_en_q;
    spi_data_d = spi_data_q;
    spi_en_d   = spi_en_q;
    res_d      = res_q;
    vbatc_d    = vbatc_q;
    vddc_d     = vddc_q;
    case (state_q)
      S_IDLE: if (bus.EN) state_d = S_FETCH;
      S_FETCH: begin
        case (entry.op)
          OP_PIN: begin
            case (entry.arg[1:0])
              PIN_VDDC:  vddc_d  = entry.arg[7];
              PIN_VBATC: vbatc_d = entry.arg[7];
              PIN_RES:   res_d   = entry.arg[7];
              default: ;
            endcase
            step_d = step_q + 5'd1;
          end
          OP_CMD: begin
            spi_data_d = entry.arg;
            spi_en_d   = 1'b1;
            state_d    = S_SEND;
          end
          OP_DLY: begin
            dly_ms_d = dly_sel(entry.arg);
            dly_en_d = 1'b1;
            state_d  = S_WAITD;
          end
          default: begin
            fin_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      // slave FIN is only trusted while our request is up, which is exactly these states
      S_SEND: if (bus.SPI_FIN) begin
        spi_en_d = 1'b0;
        step_d   = step_q + 5'd1;
        state_d  = S_GAP;
      end
      S_WAITD: if (bus.DELAY_FIN) begin
        dly_en_d = 1'b0;
        step_d   = step_q + 5'd1;
        state_d  = S_GAP;
      end
      S_GAP:  state_d = S_FETCH;
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.FIN      = fin_q;
  assign bus.DELAY_MS = dly_ms_q;
  assign bus.DELAY_EN = dly_en_q;
  assign bus.SPI_DATA = spi_data_q;
  assign bus.SPI_EN   = spi_en_q;
  assign bus.DC       = 1'b0;
  assign bus.RES      = res_q;
  assign bus.VBATC    = vbatc_q;
  assign bus.VDDC     = vddc_q;

endmodule
